// File: rtl/vmem_pkg.sv
// ============================================================================
// vmem_pkg : shared FSM encoding, region and mirror constants for vmem_arb
// Rev 1.0
// ============================================================================
`default_nettype none

package vmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PPU_BUSY  = 2'd1,
    ST_HOST_BUSY = 2'd2
  } state_e;

  // Value of addr[13] selecting each region
  localparam logic REGION_CHR = 1'b0;
  localparam logic REGION_NT  = 1'b1;

  localparam logic MIRROR_HORIZ = 1'b0;
  localparam logic MIRROR_VERT  = 1'b1;

  localparam int MAP_AW = 13;

endpackage

`default_nettype wire

// File: rtl/vmem_map.sv
// ============================================================================
// vmem_map : video address -> CHR / nametable downstream address (combinational)
// Macro VMEM_ARB_FOURSCREEN_EN selects a 4 KiB unmirrored nametable.  Rev 1.0
// ============================================================================
`default_nettype none

module vmem_map
  import vmem_pkg::*;
#(
  parameter int DS_AW = 13
) (
  input  logic [13:0]      addr,
  input  logic             mirror,
  output logic             chr_sel,
  output logic [DS_AW-1:0] ds_addr
);

  logic [MAP_AW-1:0] map_addr;

`ifdef VMEM_ARB_FOURSCREEN_EN
  logic unused_mirror;
  assign unused_mirror = mirror;
`endif

  always_comb begin
    map_addr = '0;
    chr_sel  = 1'b0;
    if (addr[13] == REGION_CHR) begin
      chr_sel  = 1'b1;
      map_addr = addr[12:0];
    end else begin
`ifdef VMEM_ARB_FOURSCREEN_EN
      map_addr = {1'b0, addr[11:0]};
`else
      // Palette addresses fall through here too; they never reach this block
      map_addr = {2'b00, (mirror == MIRROR_VERT) ? addr[10] : addr[11], addr[9:0]};
`endif
    end
    ds_addr                = '0;
    ds_addr[MAP_AW-1:0]    = map_addr;
  end

endmodule

`default_nettype wire

// File: rtl/vmem_arb.sv
// ============================================================================
// vmem_arb : PPU / host video-memory arbiter with host anti-starvation
// Macro VMEM_ARB_FOURSCREEN_EN (see vmem_map).  Rev 1.0
// ============================================================================
`default_nettype none

module vmem_arb
  import vmem_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int DS_AW      = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mirror,
  input  logic [13:0]      ppu_addr,
  input  logic [7:0]       ppu_wdata,
  input  logic             ppu_wr,
  input  logic             ppu_req,
  output logic             ppu_ack,
  output logic [7:0]       ppu_rdata,
  input  logic [13:0]      host_addr,
  input  logic [7:0]       host_wdata,
  input  logic             host_wr,
  input  logic             host_req,
  output logic             host_ack,
  output logic [7:0]       host_rdata,
  output logic             chr_sel,
  output logic [DS_AW-1:0] ds_addr,
  output logic [7:0]       ds_wdata,
  output logic             ds_wr,
  output logic             ds_req,
  input  logic [7:0]       ds_rdata,
  input  logic             ds_ack
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             grant_ppu, grant_host, force_host;
  logic             ds_req_q, ds_wr_q, chr_sel_q;
  logic [DS_AW-1:0] ds_addr_q;
  logic [7:0]       ds_wdata_q, ppu_rdata_q, host_rdata_q;
  logic             ppu_ack_q, host_ack_q;
  logic [13:0]      win_addr;
  logic             map_chr;
  logic [DS_AW-1:0] map_addr;

  assign force_host = host_req && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d    = state_q;
    grant_ppu  = 1'b0;
    grant_host = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The ack cycle is skipped: the served requester still shows req high
        if (!(ppu_ack_q || host_ack_q)) begin
          if (ppu_req && !force_host) begin
            grant_ppu = 1'b1;
            state_d   = ST_PPU_BUSY;
          end else if (host_req) begin
            grant_host = 1'b1;
            state_d    = ST_HOST_BUSY;
          end
        end
      end
      ST_PPU_BUSY, ST_HOST_BUSY: begin
        if (ds_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_host || !host_req) begin
      starve_d = '0;
    end else if (grant_ppu && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign win_addr = grant_ppu ? ppu_addr : host_addr;

  vmem_map #(
    .DS_AW (DS_AW)
  ) u_map (
    .addr    (win_addr),
    .mirror  (mirror),
    .chr_sel (map_chr),
    .ds_addr (map_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      ds_req_q     <= 1'b0;
      ds_wr_q      <= 1'b0;
      ds_addr_q    <= '0;
      ds_wdata_q   <= '0;
      chr_sel_q    <= 1'b0;
      ppu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      ppu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ppu_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      if (grant_ppu || grant_host) begin
        ds_req_q   <= 1'b1;
        ds_addr_q  <= map_addr;
        chr_sel_q  <= map_chr;
        ds_wr_q    <= grant_ppu ? ppu_wr    : host_wr;
        ds_wdata_q <= grant_ppu ? ppu_wdata : host_wdata;
      end else if (ds_ack && (state_q != ST_IDLE)) begin
        ds_req_q <= 1'b0;
        ds_wr_q  <= 1'b0;
        if (state_q == ST_PPU_BUSY) begin
          ppu_ack_q   <= 1'b1;
          ppu_rdata_q <= ds_rdata;
        end else begin
          host_ack_q   <= 1'b1;
          host_rdata_q <= ds_rdata;
        end
      end
    end
  end

  assign ds_req     = ds_req_q;
  assign ds_wr      = ds_wr_q;
  assign ds_addr    = ds_addr_q;
  assign ds_wdata   = ds_wdata_q;
  assign chr_sel    = chr_sel_q;
  assign ppu_ack    = ppu_ack_q;
  assign host_ack   = host_ack_q;
  assign ppu_rdata  = ppu_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vmem_arb.sv
// ============================================================================
// tb_vmem_arb : directed self-checking bench for vmem_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vmem_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mirror;
  logic [13:0] ppu_addr, host_addr;
  logic [7:0]  ppu_wdata, host_wdata;
  logic        ppu_wr, ppu_req, host_wr, host_req;
  logic        ppu_ack, host_ack;
  logic [7:0]  ppu_rdata, host_rdata;
  logic        chr_sel;
  logic [12:0] ds_addr;
  logic [7:0]  ds_wdata;
  logic        ds_wr, ds_req;
  logic [7:0]  ds_rdata;
  wire         ds_ack;

  logic        resp_en, resp_ack, spur_ack, resp_done;
  int          resp_lat, resp_cnt;
  logic [7:0]  resp_data;
  logic        edge_ds_ack;
  int          n_total, n_pass;

  assign ds_ack = resp_ack | spur_ack;

  always #5 clk = ~clk;

  vmem_arb #(
    .STARVE_MAX (8),
    .DS_AW      (13)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mirror     (mirror),
    .ppu_addr   (ppu_addr),
    .ppu_wdata  (ppu_wdata),
    .ppu_wr     (ppu_wr),
    .ppu_req    (ppu_req),
    .ppu_ack    (ppu_ack),
    .ppu_rdata  (ppu_rdata),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_wr    (host_wr),
    .host_req   (host_req),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .chr_sel    (chr_sel),
    .ds_addr    (ds_addr),
    .ds_wdata   (ds_wdata),
    .ds_wr      (ds_wr),
    .ds_req     (ds_req),
    .ds_rdata   (ds_rdata),
    .ds_ack     (ds_ack)
  );

  // Downstream memory model: one ack pulse resp_lat cycles into each request
  always @(negedge clk) begin
    if (!reset_n || !resp_en) begin
      resp_ack  = 1'b0;
      resp_cnt  = 0;
      resp_done = 1'b0;
    end else begin
      if (resp_ack) begin
        resp_ack  = 1'b0;
        resp_done = 1'b1;
      end else if (ds_req && !resp_done) begin
        resp_cnt = resp_cnt + 1;
        if (resp_cnt >= resp_lat) begin
          resp_ack = 1'b1;
          ds_rdata = resp_data;
          resp_cnt = 0;
        end
      end
      if (!ds_req) resp_done = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    edge_ds_ack = ds_ack;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ds_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (ds_req) break;
      tick();
    end
    check(tag, {31'd0, ds_req}, 32'd1);
  endtask

  task automatic wait_any_ack(output logic p, output logic h, output logic prev);
    p = 1'b0; h = 1'b0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ppu_ack || host_ack) begin
        p = ppu_ack; h = host_ack; prev = edge_ds_ack;
        break;
      end
    end
  endtask

  logic p, h, prev, bad;
  int   extra;

  initial begin
    n_total = 0; n_pass = 0;
    reset_n = 1'b0; mirror = 1'b0;
    ppu_addr = '0; ppu_wdata = '0; ppu_wr = 1'b0; ppu_req = 1'b0;
    host_addr = '0; host_wdata = '0; host_wr = 1'b0; host_req = 1'b0;
    ds_rdata = '0; resp_en = 1'b1; resp_lat = 2; resp_data = 8'h00;
    spur_ack = 1'b0; resp_ack = 1'b0; resp_done = 1'b0; resp_cnt = 0;
    edge_ds_ack = 1'b0;
    repeat (3) tick();

    check("rst_ds_req",   {31'd0, ds_req},   32'd0);
    check("rst_ds_wr",    {31'd0, ds_wr},    32'd0);
    check("rst_acks",     {30'd0, ppu_ack, host_ack}, 32'd0);
    check("rst_ds_addr",  {19'd0, ds_addr},  32'd0);
    check("rst_ds_wdata", {24'd0, ds_wdata}, 32'd0);
    check("rst_rdata",    {16'd0, ppu_rdata, host_rdata}, 32'd0);
    check("rst_chr_sel",  {31'd0, chr_sel},  32'd0);

    @(negedge clk); reset_n = 1'b1;
    tick();

    // PPU read 0x2400, horizontal mirroring, mirror toggled mid-transaction
    resp_lat = 2; resp_data = 8'hA7;
    ppu_addr = 14'h2400; ppu_wr = 1'b0; ppu_req = 1'b1; mirror = 1'b0;
    tick();
    wait_ds_req("ppu_nt_req");
    check("ppu_nt_addr", {19'd0, ds_addr}, 32'h0000);
    check("ppu_nt_chr",  {31'd0, chr_sel}, 32'd0);
    check("ppu_nt_wr",   {31'd0, ds_wr},   32'd0);
    mirror = 1'b1;
    tick();
    check("mirror_hold", {19'd0, ds_addr}, 32'h0000);
    wait_any_ack(p, h, prev);
    ppu_req = 1'b0;
    check("ppu_nt_ack",   {30'd0, p, h}, 32'b10);
    check("ppu_ack_lat",  {31'd0, prev}, 32'd1);
    check("ppu_nt_rdata", {24'd0, ppu_rdata}, 32'hA7);
    tick();
    check("ppu_ack_pulse", {30'd0, ppu_ack, ds_req}, 32'd0);

    // Host write 0x2400 = 0x5A, vertical mirroring
    mirror = 1'b1; resp_lat = 1;
    host_addr = 14'h2400; host_wdata = 8'h5A; host_wr = 1'b1; host_req = 1'b1;
    tick();
    wait_ds_req("host_wr_req");
    check("host_wr_addr",  {19'd0, ds_addr},  32'h0400);
    check("host_wr_wr",    {31'd0, ds_wr},    32'd1);
    check("host_wr_wdata", {24'd0, ds_wdata}, 32'h5A);
    wait_any_ack(p, h, prev);
    host_req = 1'b0; host_wr = 1'b0;
    check("host_wr_ack", {30'd0, p, h}, 32'b01);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (host_ack || ppu_ack) extra++;
    end
    check("host_wr_once", extra, 0);

    // PPU read in CHR space
    resp_data = 8'h3C;
    ppu_addr = 14'h1ABC; ppu_req = 1'b1;
    tick();
    wait_ds_req("chr_req");
    check("chr_sel",  {31'd0, chr_sel}, 32'd1);
    check("chr_addr", {19'd0, ds_addr}, 32'h1ABC);
    wait_any_ack(p, h, prev);
    ppu_req = 1'b0;
    check("chr_rdata", {24'd0, ppu_rdata}, 32'h3C);
    repeat (2) tick();

    // 0x2C05 with mirror=0 (addr[11]=1), then mirror=1 (addr[10]=1)
    mirror = 1'b0; ppu_addr = 14'h2C05; ppu_req = 1'b1;
    tick();
    wait_ds_req("nt_h_req");
`ifdef VMEM_ARB_FOURSCREEN_EN
    check("nt_h_addr", {19'd0, ds_addr}, 32'h0C05);
`else
    check("nt_h_addr", {19'd0, ds_addr}, 32'h0405);
`endif
    wait_any_ack(p, h, prev);
    ppu_req = 1'b0;
    repeat (2) tick();
    mirror = 1'b1; ppu_req = 1'b1;
    tick();
    wait_ds_req("nt_v_req");
`ifdef VMEM_ARB_FOURSCREEN_EN
    check("nt_v_addr", {19'd0, ds_addr}, 32'h0C05);
`else
    check("nt_v_addr", {19'd0, ds_addr}, 32'h0405);
`endif
    wait_any_ack(p, h, prev);
    ppu_req = 1'b0;
    repeat (2) tick();

    // Spurious downstream ack while idle
    resp_en = 1'b0;
    @(negedge clk); spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ppu_ack || host_ack || ds_req) bad = 1'b1;
    end
    check("spurious_ack", {31'd0, bad}, 32'd0);
    resp_en = 1'b1;

    // Both requesters held: 8 PPU grants, then 1 host, repeating
    resp_lat = 1;
    ppu_addr = 14'h0010; host_addr = 14'h0020; host_wr = 1'b0;
    ppu_req = 1'b1; host_req = 1'b1;
    for (int k = 0; k < 18; k++) begin
      wait_any_ack(p, h, prev);
      check($sformatf("starve_seq%0d", k), {30'd0, p, h},
            (k == 8 || k == 17) ? 32'b01 : 32'b10);
    end
    ppu_req = 1'b0; host_req = 1'b0;
    repeat (3) tick();
    check("starve_idle", {31'd0, ds_req}, 32'd0);

    // Reset while a transaction is outstanding
    resp_en = 1'b0;
    ppu_addr = 14'h0123; ppu_req = 1'b1;
    tick();
    wait_ds_req("rst_mid_req");
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl",  {28'd0, ds_req, ds_wr, ppu_ack, host_ack}, 32'd0);
    check("rst_mid_addr",  {19'd0, ds_addr}, 32'd0);
    check("rst_mid_data",  {8'd0, ds_wdata, ppu_rdata, host_rdata}, 32'd0);
    check("rst_mid_chr",   {31'd0, chr_sel}, 32'd0);
    ppu_req = 1'b0;
    repeat (2) tick();
    @(negedge clk); reset_n = 1'b1; resp_en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ppu_ack || host_ack || ds_req) bad = 1'b1;
    end
    check("rst_no_stale", {31'd0, bad}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vmem_arb.md
VMEM_ARB -- requirements
Module: vmem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8: max consecutive PPU grants while host waits before host is forced.
REQ-002 SHALL have parameter DS_AW, default 13: downstream address width.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 mirror  in  1  nametable mirroring: 0 horizontal, 1 vertical.
REQ-006 ppu_addr/ppu_wdata/ppu_wr/ppu_req  in  14/8/1/1  PPU video-memory request.
REQ-007 ppu_ack  out  1  one-cycle PPU completion pulse.
REQ-008 ppu_rdata  out  8  PPU read data, valid with ppu_ack.
REQ-009 host_addr/host_wdata/host_wr/host_req  in  14/8/1/1  host/loader request.
REQ-010 host_ack  out  1  one-cycle host completion pulse.
REQ-011 host_rdata  out  8  host read data, valid with host_ack.
REQ-012 chr_sel  out  1  1 = CHR memory, 0 = nametable RAM.
REQ-013 ds_addr/ds_wdata/ds_wr/ds_req  out  DS_AW/8/1/1  downstream request, registered.
REQ-014 ds_rdata/ds_ack  in  8/1  downstream read data and one-cycle completion.

Function
REQ-015 SHALL be a 3-state FSM: IDLE, PPU_BUSY, HOST_BUSY.
REQ-016 IDLE: ppu_req without forced-host condition -> PPU_BUSY; else host_req -> HOST_BUSY; else stay.
REQ-017 Forced-host condition: host_req high and starve count == STARVE_MAX; then host wins over ppu_req.
REQ-018 On grant, next cycle ds_req=1 with mapped address, wdata and wr latched from the winner; requester inputs are ignored until completion.
REQ-019 ds_req SHALL stay high until the cycle ds_ack is seen, then drop the following cycle.
REQ-020 On ds_ack, the granted requester's ack pulses the next cycle, its rdata = ds_rdata registered, and FSM returns to IDLE.
REQ-021 Requester holds req until its ack; arbiter re-arbitrates in IDLE, so back-to-back service costs 1 idle cycle minimum.
REQ-022 Starve count: +1 (saturating at STARVE_MAX) on each PPU grant while host_req high; cleared on host grant or host_req low.
REQ-023 Address map: addr[13]=0 -> chr_sel=1, ds_addr=addr[12:0].
REQ-024 addr[13]=1 -> chr_sel=0, ds_addr = {2'b0, A, addr[9:0]}; A=addr[10] if mirror=1, A=addr[11] if mirror=0.
REQ-025 addr >= 0x3F00 (palette) SHALL still map as nametable; palette is held in the PPU and such requests never reach this block.
REQ-026 mirror SHALL be sampled at grant; changes mid-transaction do not affect it.
REQ-027 ppu_ack and host_ack SHALL never be high in the same cycle.
REQ-028 A ds_ack arriving in IDLE (spurious) SHALL be ignored.

Reset
REQ-029 While reset_n low: FSM IDLE, starve count 0, ds_req/ds_wr/ppu_ack/host_ack 0, ds_addr/ds_wdata/rdata outputs 0, chr_sel 0.
REQ-030 Reset mid-transaction SHALL abandon it; no ack is issued for it after release.

Configuration
REQ-031 Macro VMEM_ARB_FOURSCREEN_EN.
REQ-032 Defined: nametable ds_addr = {1'b0, addr[11:0]} (4 KiB, no mirroring); mirror is ignored.
REQ-033 Undefined: 2 KiB mirroring per REQ-024.

Structure
REQ-034 Shared package vmem_pkg SHALL hold the FSM state encoding, CHR/nametable region constants and the mirror encoding.
REQ-035 Address mapping SHALL be one combinational sub-module vmem_map (addr, mirror -> chr_sel, ds_addr), instantiated once on the winner's address.

Verification
REQ-036 PPU read 0x2400, mirror=0, ds_ack 2 cycles after ds_req -> ds_addr=0x0000, chr_sel=0, ppu_ack 1 cycle after ds_ack, ppu_rdata=ds_rdata.
REQ-037 Host write 0x2400=0x5A, mirror=1 -> ds_addr=0x0400, ds_wr=1, ds_wdata=0x5A, host_ack once.
REQ-038 ppu_req and host_req held continuously, STARVE_MAX=8 -> exactly 8 PPU grants, then 1 host grant, pattern repeats; never both acks together.
REQ-039 PPU read 0x1ABC -> chr_sel=1, ds_addr=0x1ABC.
REQ-040 reset_n low while ds_req high, then released -> all outputs 0, FSM IDLE, no stale ack.
REQ-041 With VMEM_ARB_FOURSCREEN_EN: read 0x2C05 -> ds_addr=0x0C05 for both mirror values.
